// File: rtl/clock_ctrl.sv
// clock_ctrl: generates the one-cycle CPU clock-enable from the system clock.
// Free-run at a programmable rate, single-step from a debounced push-button,
// or halt (absorbing until reset) on the CPU HLT request.
module clock_ctrl #(
   parameter int DIV_WIDTH       = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_mode,
   input  logic                 step_btn,
   input  logic                 hlt,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 cpu_ce,
   output logic                 halted,
   output logic [15:0]          tick_count
);

   // Stability counter saturates at DEBOUNCE_CYCLES-1: once there, the
   // synchronized level has matched its previous sample DEBOUNCE_CYCLES times.
   localparam int              DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_MANUAL = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_sync_prev;
   logic [DB_W-1:0]      r_db_cnt;
   logic                 r_btn_state;
   logic                 r_btn_d;
   logic                 w_step_req;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DIV_WIDTH-1:0] r_div_cnt;
   logic [DIV_WIDTH-1:0] w_div_cnt_nxt;
   logic                 w_ce_nxt;
   logic                 r_cpu_ce;
   logic                 r_halted;
   logic [15:0]          r_tick_count;

   // Two-flop synchronizer bringing the raw button into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= step_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: a new level is accepted only after it has held steady
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_prev <= 1'b0;
         r_db_cnt    <= '0;
         r_btn_state <= 1'b0;
         r_btn_d     <= 1'b0;
      end else begin
         r_sync_prev <= r_sync2;
         r_btn_d     <= r_btn_state;
         if (r_sync2 != r_sync_prev) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt != DB_LAST) begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
         if ((r_sync2 == r_sync_prev) && (r_db_cnt == DB_LAST) &&
             (r_sync2 != r_btn_state)) begin
            r_btn_state <= r_sync2;
         end
      end
   end

   // Rising edge of the debounced level: one request per press, however long held
   assign w_step_req = r_btn_state & ~r_btn_d;

   // Mode FSM state, divider and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_MANUAL;
         r_div_cnt <= '0;
         r_cpu_ce  <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_cnt_nxt;
         r_cpu_ce  <= w_ce_nxt;
         r_halted  <= (w_state_nxt == S_HALTED);
      end
   end

   // Next-state and next clock-enable; halt beats everything, then mode change
   always_comb begin
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
      w_ce_nxt      = 1'b0;
      case (r_state)
         S_MANUAL: begin
            if (hlt) begin
               w_state_nxt = S_HALTED;
            end else if (run_mode) begin
               w_state_nxt   = S_RUN;
               w_div_cnt_nxt = '0;
            end else if (w_step_req) begin
               w_ce_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (hlt) begin
               w_state_nxt = S_HALTED;
            end else if (!run_mode) begin
               w_state_nxt = S_MANUAL;
            end else if (r_div_cnt >= div) begin
               // >= so a lowered div takes effect at once instead of wrapping
               w_ce_nxt      = 1'b1;
               w_div_cnt_nxt = '0;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_MANUAL;
         end
      endcase
   end

   // Count delivered pulses; wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_count <= 16'd0;
      end else if (r_cpu_ce) begin
         r_tick_count <= r_tick_count + 16'd1;
      end
   end

   assign cpu_ce     = r_cpu_ce;
   assign halted     = r_halted;
   assign tick_count = r_tick_count;

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Synthesizable clock-control unit for the 8-bit computer; the design-side driver of the CPU clock rather than a simulation oscillator.
- Generates a one-cycle clock-enable `cpu_ce` from the single system clock.
- Modes: free-run at a programmable rate, manual single-step from a debounced push-button, and halt on the CPU HLT signal.
- Sits between the front-panel/testbench controls and every CPU register's clock-enable input.

Parameters:
- DIV_WIDTH, 8, width of the rate divider input `div`.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new button level (must be >= 1).

Ports:
- clk  input  1  system clock; the only clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- run_mode  input  1  1 = free-run, 0 = manual single-step; synchronous level.
- step_btn  input  1  raw asynchronous push-button, active-high.
- hlt  input  1  CPU halt request, synchronous level.
- div  input  DIV_WIDTH  free-run period minus one: one tick every div+1 cycles.
- cpu_ce  output  1  registered one-cycle CPU clock-enable pulse.
- halted  output  1  registered; 1 while in HALTED.
- tick_count  output  16  number of cpu_ce pulses since reset.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears everything in one edge: state=MANUAL, cpu_ce=0, halted=0, tick_count=0, div_cnt=0.
  - Synchronizer flops, debounce counter, debounced level and edge register all clear to 0.
  - Reset mid-pulse or mid-debounce discards all in-progress activity.
- Button path:
  - 2-flop synchronizer on step_btn, giving sync_btn.
  - Debounce counter restarts whenever sync_btn differs from the previous sample.
  - When sync_btn has been stable for DEBOUNCE_CYCLES consecutive cycles and differs from btn_state, btn_state takes the new value.
  - step_req is a 1-cycle pulse on the rising edge of btn_state.
  - One press gives exactly one step_req regardless of hold length; glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states: MANUAL, RUN, HALTED.
- MANUAL:
  - hlt=1 goes to HALTED (highest priority).
  - Else run_mode=1 goes to RUN, with div_cnt cleared.
  - Else step_req=1 gives cpu_ce=1 on the next cycle, for one cycle.
- RUN:
  - hlt=1 goes to HALTED; cpu_ce is forced to 0 next cycle, suppressing any coincident terminal pulse.
  - Else run_mode=0 goes to MANUAL; cpu_ce=0 next cycle.
  - Else divider runs: if div_cnt >= div, then cpu_ce<=1 and div_cnt<=0; otherwise cpu_ce<=0 and div_cnt<=div_cnt+1.
  - The >= compare makes a mid-run decrease of div take effect without a long wrap.
  - Period is div+1 cycles. div=0 gives cpu_ce high every cycle.
  - First pulse is visible on the (div+1)th cycle after state becomes RUN.
- HALTED:
  - Absorbing state; left only by reset.
  - halted=1 and cpu_ce=0; step_req and run_mode are ignored.
- Other cpu_ce rules:
  - step_req in RUN or HALTED is discarded, never queued.
  - cpu_ce is never high two consecutive cycles except in RUN with div=0.
- tick_count:
  - Increments the cycle after each cpu_ce=1, so it equals the count of pulses observed.
  - Wraps from 0xFFFF to 0x0000.
- No combinational path from any input to any output.

Test Plan:
1. Reset held 3 cycles with run_mode=1, div=3 → cpu_ce=0, halted=0, tick_count=0 during reset. After release: state RUN; cpu_ce pulses every 4 cycles; tick_count=5 after 20 cycles of RUN.
2. run_mode=0, DEBOUNCE_CYCLES=4, step_btn held high 50 cycles then low → exactly one cpu_ce pulse, about 2+4+1 cycles after the press; tick_count=1. A 2-cycle glitch gives no pulse.
3. RUN, div=0 for 10 cycles → cpu_ce high all 10 cycles. Then div=5 → period 6; change div from 200 to 2 mid-count → pulse on the next cycle, then period 3.
4. RUN, div=3: assert hlt on the cycle where div_cnt==3 → no cpu_ce pulse follows, halted=1 next cycle. Then a step press and run_mode toggles → cpu_ce stays 0 and halted stays 1 until reset.
5. Step press while run_mode=1 → no extra cpu_ce beyond the divider cadence. Switching run_mode to 0 afterwards → no delayed or queued step pulse.
6. Preload by running div=0 for 65536 cycles → tick_count wraps to 0x0000. Assert reset mid-run → all outputs 0 on the next edge.
